// File: rtl/qn_readout_pkg.sv
// Shared definitions for the tube readout path.
//   seq_state_t  : event sequencer states
//   TRAILER_WORD : end-of-event marker written after the last tube word
//   tube_name()  : 8-bit channel tag placed in fifo_din[7:0]; the Raspberry Pi
//                  decoder model uses the same mapping
package qn_readout_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GATE,
        ST_SCAN,
        ST_TRAIL,
        ST_CLEAR
    } seq_state_t;

    localparam logic [15:0] TRAILER_WORD = 16'hFFFF;

    // name(i) = {i[2:0], i[3], 3 + i[4]}: ch0=8'h03, ch9=8'h33, ch16=8'h04, ch31=8'hF4
    function automatic logic [7:0] tube_name(input logic [4:0] i);
        logic [3:0] bank;
        bank = 4'd3 + {3'b000, i[4]};
        return {i[2:0], i[3], bank};
    endfunction

endpackage

// File: rtl/event_readout_sequencer_coin_edge_sync.sv
// Brings the asynchronous scintillator coincidence into clk50 and flags its
// rising edge for exactly one cycle.
//   clk50      in  system clock
//   clr        in  async active-high reset
//   coin_async in  scintillator coincidence, asynchronous to clk50
//   coin_rise  out one-cycle pulse on a rising edge of the synchronised signal
module coin_edge_sync (
    input  logic clk50,
    input  logic clr,
    input  logic coin_async,
    output logic coin_rise
);

    // [0],[1]: two-flop synchroniser; [2]: previous synchronised value
    logic [2:0] sync_q;

    always_ff @(posedge clk50 or posedge clr) begin
        if (clr) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], coin_async};
        end
    end

    assign coin_rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/event_readout_sequencer.sv
// Sequences one scintillator-triggered event: gate window, scan of every tube
// time channel into the readout FIFO as {time, name}, trailer word, then a
// tube clear pulse before re-arming. Stalls (without loss) on FIFO full.
//   clk50       in  system clock
//   clr         in  async active-high reset
//   scin_coin   in  scintillator coincidence (asynchronous)
//   tube_data   in  NUM_TUBES x 8-bit tube times, channel i at [8i+7:8i]
//   fifo_full   in  FIFO full flag
//   tube_gate   out gate enable to all tubes
//   tube_clr    out clear to all tubes
//   fifo_din    out FIFO word, [15:8] time, [7:0] name; TRAILER when idle
//   fifo_wr_en  out one-cycle write strobe per word (registered)
//   busy        out high outside IDLE
//   overflow    out sticky: a write was held off by fifo_full
//   evt_count   out completed events, wrapping
//   drop_count  out triggers ignored while busy, saturating
module event_readout_sequencer
    import qn_readout_pkg::*;
#(
    parameter int unsigned NUM_TUBES   = 32,
    parameter int unsigned GATE_CYCLES = 256,
    parameter int unsigned CLR_CYCLES  = 11,
    parameter logic [15:0] TRAILER     = TRAILER_WORD
) (
    input  logic                   clk50,
    input  logic                   clr,
    input  logic                   scin_coin,
    input  logic [NUM_TUBES*8-1:0] tube_data,
    input  logic                   fifo_full,
    output logic                   tube_gate,
    output logic                   tube_clr,
    output logic [15:0]            fifo_din,
    output logic                   fifo_wr_en,
    output logic                   busy,
    output logic                   overflow,
    output logic [15:0]            evt_count,
    output logic [7:0]             drop_count
);

    localparam int unsigned IDX_W  = (NUM_TUBES > 1) ? $clog2(NUM_TUBES) : 1;
    localparam int unsigned GATE_W = $clog2(GATE_CYCLES + 1);
    localparam int unsigned CLRC_W = $clog2(CLR_CYCLES + 1);

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_TUBES - 1);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CLRC_W-1:0] CLR_LAST  = CLRC_W'(CLR_CYCLES - 1);

    logic trig;

    coin_edge_sync u_coin_sync (
        .clk50      (clk50),
        .clr        (clr),
        .coin_async (scin_coin),
        .coin_rise  (trig)
    );

    logic [NUM_TUBES-1:0][7:0] tube_time;
    assign tube_time = tube_data;

    seq_state_t        state_q, state_d;
    logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
    logic [CLRC_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [15:0]       fifo_din_q, fifo_din_d;
    logic              fifo_wr_en_q, fifo_wr_en_d;
    logic              overflow_q, overflow_d;
    logic [15:0]       evt_count_q, evt_count_d;
    logic [7:0]        drop_count_q, drop_count_d;

    always_ff @(posedge clk50 or posedge clr) begin
        if (clr) begin
            state_q      <= ST_IDLE;
            gate_cnt_q   <= '0;
            clr_cnt_q    <= '0;
            idx_q        <= '0;
            fifo_din_q   <= TRAILER;
            fifo_wr_en_q <= 1'b0;
            overflow_q   <= 1'b0;
            evt_count_q  <= '0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            gate_cnt_q   <= gate_cnt_d;
            clr_cnt_q    <= clr_cnt_d;
            idx_q        <= idx_d;
            fifo_din_q   <= fifo_din_d;
            fifo_wr_en_q <= fifo_wr_en_d;
            overflow_q   <= overflow_d;
            evt_count_q  <= evt_count_d;
            drop_count_q <= drop_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        gate_cnt_d   = gate_cnt_q;
        clr_cnt_d    = clr_cnt_q;
        idx_d        = idx_q;
        fifo_din_d   = TRAILER;
        fifo_wr_en_d = 1'b0;
        overflow_d   = overflow_q;
        evt_count_d  = evt_count_q;
        drop_count_d = drop_count_q;

        // Any trigger outside IDLE (including the last CLEAR cycle) is dropped
        if (trig && (state_q != ST_IDLE) && (drop_count_q != 8'hFF)) begin
            drop_count_d = drop_count_q + 8'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (trig) begin
                    state_d    = ST_GATE;
                    gate_cnt_d = '0;
                end
            end
            ST_GATE: begin
                if (gate_cnt_q == GATE_LAST) begin
                    state_d = ST_SCAN;
                    idx_d   = '0;
                end else begin
                    gate_cnt_d = gate_cnt_q + GATE_W'(1);
                end
            end
            ST_SCAN: begin
                // idx only advances on an accepted write, so a stall resumes on the same channel
                if (fifo_full) begin
                    overflow_d = 1'b1;
                end else begin
                    fifo_din_d   = {tube_time[idx_q], tube_name(5'(idx_q))};
                    fifo_wr_en_d = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_TRAIL;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_TRAIL: begin
                if (fifo_full) begin
                    overflow_d = 1'b1;
                end else begin
                    fifo_din_d   = TRAILER;
                    fifo_wr_en_d = 1'b1;
                    evt_count_d  = evt_count_q + 16'd1;
                    state_d      = ST_CLEAR;
                    clr_cnt_d    = '0;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt_q == CLR_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + CLRC_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign tube_gate  = (state_q == ST_GATE);
    assign tube_clr   = (state_q == ST_CLEAR);
    assign busy       = (state_q != ST_IDLE);
    assign fifo_din   = fifo_din_q;
    assign fifo_wr_en = fifo_wr_en_q;
    assign overflow   = overflow_q;
    assign evt_count  = evt_count_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_event_readout_sequencer.sv
module tb_event_readout_sequencer;

    localparam int NT = 32;

    logic          clk50 = 1'b0;
    logic          clr = 1'b0;
    logic          scin_coin = 1'b0;
    logic [NT*8-1:0] tube_data;
    logic          fifo_full = 1'b0;
    logic          tube_gate, tube_clr, fifo_wr_en, busy, overflow;
    logic [15:0]   fifo_din, evt_count;
    logic [7:0]    drop_count;

    int checks = 0;
    int errors = 0;

    event_readout_sequencer #(
        .NUM_TUBES   (NT),
        .GATE_CYCLES (256),
        .CLR_CYCLES  (11),
        .TRAILER     (16'hFFFF)
    ) dut (
        .clk50      (clk50),
        .clr        (clr),
        .scin_coin  (scin_coin),
        .tube_data  (tube_data),
        .fifo_full  (fifo_full),
        .tube_gate  (tube_gate),
        .tube_clr   (tube_clr),
        .fifo_din   (fifo_din),
        .fifo_wr_en (fifo_wr_en),
        .busy       (busy),
        .overflow   (overflow),
        .evt_count  (evt_count),
        .drop_count (drop_count)
    );

    always #10 clk50 = ~clk50;

    // ---------------- monitor ----------------
    logic [15:0] words[$];
    logic full_at_edge = 1'b0;
    int   cyc = 0;
    int   gate_hi = 0, clr_hi = 0, busy_hi = 0, stall_viol = 0;
    int   gate_rise_cyc = -1, first_wr_cyc = -1;
    logic prev_gate = 1'b0;

    always @(posedge clk50) full_at_edge = fifo_full;

    always @(negedge clk50) begin
        cyc++;
        if (tube_gate) gate_hi++;
        if (tube_clr) clr_hi++;
        if (busy) busy_hi++;
        if (tube_gate && !prev_gate && gate_rise_cyc < 0) gate_rise_cyc = cyc;
        prev_gate = tube_gate;
        if (fifo_wr_en) begin
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
            if (full_at_edge) stall_viol++;
            words.push_back(fifo_din);
        end
    end

    task automatic clear_mon();
        words.delete();
        gate_hi = 0; clr_hi = 0; busy_hi = 0; stall_viol = 0;
        gate_rise_cyc = -1; first_wr_cyc = -1;
    endtask

    // ---------------- helpers ----------------
    function automatic logic [7:0] exp_name(input int i);
        logic [4:0] b;
        b = 5'(i);
        return {b[2:0], b[3], (b[4] ? 4'h4 : 4'h3)};
    endfunction

    function automatic logic [15:0] exp_word(input int i);
        logic [7:0] t;
        if (i >= NT) return 16'hFFFF;
        t = 8'(i + 1);
        return {t, exp_name(i)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk50);
        #1;
    endtask

    task automatic do_reset();
        clr = 1'b1;
        step();
        clr = 1'b0;
        step();
        clear_mon();
    endtask

    task automatic trigger();
        scin_coin = 1'b1;
        step();
        scin_coin = 1'b0;
        step();
    endtask

    task automatic wait_busy(input string tag);
        int k = 0;
        while (!busy && k < 20) begin step(); k++; end
        check(tag, 32'(busy), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 3000) begin step(); k++; end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic wait_words(input int n, input string tag);
        int k = 0;
        while (words.size() < n && k < 1000) begin step(); k++; end
        check(tag, 32'(words.size() >= n), 32'd1);
    endtask

    task automatic check_event(input string tag, input int base);
        check({tag, "_len"}, 32'(words.size() >= base + NT + 1), 32'd1);
        if (words.size() >= base + NT + 1) begin
            for (int i = 0; i <= NT; i++)
                check($sformatf("%s_w%0d", tag, i), 32'(words[base + i]), 32'(exp_word(i)));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        for (int i = 0; i < NT; i++) tube_data[8*i +: 8] = 8'(i + 1);

        // Reset state
        clr = 1'b1;
        #5;
        check("rst_busy", 32'(busy), 0);
        check("rst_gate", 32'(tube_gate), 0);
        check("rst_tclr", 32'(tube_clr), 0);
        check("rst_wr", 32'(fifo_wr_en), 0);
        check("rst_din", 32'(fifo_din), 32'hFFFF);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_evt", 32'(evt_count), 0);
        check("rst_drop", 32'(drop_count), 0);
        step();
        clr = 1'b0;
        step();
        clear_mon();

        // 1/2: single event, content and timing
        trigger();
        wait_busy("t1_start");
        wait_idle("t1_done");
        step();
        check_event("t1", 0);
        check("t1_count", 32'(words.size()), 33);
        check("t1_evt", 32'(evt_count), 1);
        check("t1_gate_len", 32'(gate_hi), 256);
        check("t1_tclr_len", 32'(clr_hi), 11);
        check("t1_busy_len", 32'(busy_hi), 300);
        check("t1_latency", 32'(first_wr_cyc - gate_rise_cyc), 257);
        check("t1_ovf", 32'(overflow), 0);
        check("t1_drop", 32'(drop_count), 0);
        check("t1_din_idle", 32'(fifo_din), 32'hFFFF);

        // 3: stall of 5 cycles at idx 10
        do_reset();
        trigger();
        wait_words(10, "t3_reach10");
        fifo_full = 1'b1;
        repeat (5) step();
        check("t3_no_write", 32'(words.size()), 10);
        fifo_full = 1'b0;
        wait_idle("t3_done");
        step();
        check_event("t3", 0);
        check("t3_count", 32'(words.size()), 33);
        check("t3_stall_viol", 32'(stall_viol), 0);
        check("t3_ovf", 32'(overflow), 1);
        repeat (20) step();
        check("t3_ovf_sticky", 32'(overflow), 1);
        check("t3_evt", 32'(evt_count), 1);

        // 4a: three extra triggers during SCAN
        do_reset();
        trigger();
        wait_words(1, "t4_scan");
        repeat (3) begin
            scin_coin = 1'b1; step();
            scin_coin = 1'b0; step(); step();
        end
        wait_idle("t4_done");
        repeat (10) step();
        check("t4_drop", 32'(drop_count), 3);
        check("t4_evt", 32'(evt_count), 1);
        check("t4_count", 32'(words.size()), 33);
        check("t4_idle", 32'(busy), 0);

        // 4b: 300 triggers while held in SCAN -> saturation
        clear_mon();
        trigger();
        wait_words(1, "t4b_scan");
        fifo_full = 1'b1;
        repeat (300) begin
            scin_coin = 1'b1; step();
            scin_coin = 1'b0; step();
        end
        repeat (5) step();
        check("t4b_drop_sat", 32'(drop_count), 32'hFF);
        fifo_full = 1'b0;
        wait_idle("t4b_done");
        step();
        check("t4b_count", 32'(words.size()), 33);
        check("t4b_evt", 32'(evt_count), 2);

        // 5: clr mid-scan at idx 5
        do_reset();
        trigger();
        wait_words(5, "t5_reach5");
        clr = 1'b1;
        #1;
        check("t5_busy", 32'(busy), 0);
        check("t5_wr", 32'(fifo_wr_en), 0);
        check("t5_din", 32'(fifo_din), 32'hFFFF);
        check("t5_gate", 32'(tube_gate), 0);
        check("t5_tclr", 32'(tube_clr), 0);
        check("t5_evt", 32'(evt_count), 0);
        step();
        clr = 1'b0;
        step();
        clear_mon();
        trigger();
        wait_busy("t5_restart");
        wait_idle("t5_done");
        step();
        check_event("t5", 0);
        check("t5_count", 32'(words.size()), 33);
        check("t5_evt_after", 32'(evt_count), 1);

        // 6: back-to-back triggers, each 1 cycle after return to IDLE
        do_reset();
        trigger();
        wait_busy("t6_a_start");
        wait_idle("t6_a_done");
        step();
        trigger();
        wait_busy("t6_b_start");
        wait_idle("t6_b_done");
        step();
        check("t6_count", 32'(words.size()), 66);
        check_event("t6a", 0);
        check_event("t6b", 33);
        check("t6_evt", 32'(evt_count), 2);
        check("t6_drop", 32'(drop_count), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
